// File: rtl/conv_seq_ctrl.sv
// Conv layer pass sequencer: walks in_tile/col/row/out_tile over a tiled input stream and drives
// the conv datapath controls, with a latency-matched output valid and 3x3 window-edge masking.
module conv_seq_ctrl #(
  parameter int ROW_BUFFER_DEPTH     = 9,
  parameter int DIM_WIDTH            = 9,
  parameter int TILE_WIDTH           = 6,
  parameter int SCALE_WIDTH          = 4,
  parameter int MULT_PIPELINE_STAGE  = 2,
  parameter int ADDER_PIPELINE_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cfg_pw_mode,
  input  logic [DIM_WIDTH-1:0]        cfg_img_w,
  input  logic [DIM_WIDTH-1:0]        cfg_img_h,
  input  logic [TILE_WIDTH-1:0]       cfg_in_tiles,
  input  logic [TILE_WIDTH-1:0]       cfg_out_tiles,
  input  logic [SCALE_WIDTH-1:0]      cfg_scale,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        state_rst,
  output logic                        adder_rst,
  output logic                        acc_last,
  output logic                        out_valid,
  output logic [SCALE_WIDTH-1:0]      scale_in,
  output logic                        PW_mode,
  output logic [ROW_BUFFER_DEPTH-1:0] buff_len_ctrl,
  output logic                        buff_len_rst
);

  localparam int LAT = MULT_PIPELINE_STAGE + ADDER_PIPELINE_STAGE;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] REARM = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]                  state_q, state_d;
  logic                        pw_q;
  logic [SCALE_WIDTH-1:0]      scale_q;
  logic [DIM_WIDTH-1:0]        w_last_q, h_last_q;
  logic [TILE_WIDTH-1:0]       in_last_q, out_last_q;
  logic [ROW_BUFFER_DEPTH-1:0] buff_len_q;
  logic [TILE_WIDTH-1:0]       in_tile_q, out_tile_q;
  logic [DIM_WIDTH-1:0]        col_q, row_q;
  logic [7:0]                  drain_q;
  logic [LAT-1:0]              lat_sr_q, lat_sr_d;

  logic [DIM_WIDTH-1:0]        w_clamp;
  logic [ROW_BUFFER_DEPTH-1:0] therm;
  logic accepted, in_tile_last, col_last, row_last, out_last, pass_beat_last, win;

  always_comb begin
    w_clamp = cfg_img_w;
    if (cfg_img_w == '0) begin
      w_clamp = DIM_WIDTH'(1);
    end else if (cfg_img_w > DIM_WIDTH'(ROW_BUFFER_DEPTH)) begin
      w_clamp = DIM_WIDTH'(ROW_BUFFER_DEPTH);
    end
    therm = '0;
    for (int i = 0; i < ROW_BUFFER_DEPTH; i++) begin
      therm[i] = (i < int'(w_clamp));
    end
  end

  assign accepted       = (state_q == RUN) & in_valid;
  assign in_tile_last   = (in_tile_q == in_last_q);
  assign col_last       = (col_q == w_last_q);
  assign row_last       = (row_q == h_last_q);
  assign out_last       = (out_tile_q == out_last_q);
  assign pass_beat_last = accepted & in_tile_last & col_last & row_last;
  // A 3x3 output exists only once the window has two rows/cols of history behind it.
  assign win = pw_q | ((row_q >= DIM_WIDTH'(2)) & (col_q >= DIM_WIDTH'(2)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (pass_beat_last) state_d = out_last ? DRAIN : REARM;
      REARM:   state_d = RUN;
      DRAIN:   if (drain_q >= 8'(LAT - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pw_q       <= 1'b0;
      scale_q    <= '0;
      w_last_q   <= '0;
      h_last_q   <= '0;
      in_last_q  <= '0;
      out_last_q <= '0;
      buff_len_q <= '0;
      in_tile_q  <= '0;
      out_tile_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      drain_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          pw_q       <= cfg_pw_mode;
          scale_q    <= cfg_scale;
          w_last_q   <= w_clamp - DIM_WIDTH'(1);
          h_last_q   <= (cfg_img_h == '0) ? '0 : cfg_img_h - DIM_WIDTH'(1);
          in_last_q  <= (cfg_in_tiles == '0) ? '0 : cfg_in_tiles - TILE_WIDTH'(1);
          out_last_q <= (cfg_out_tiles == '0) ? '0 : cfg_out_tiles - TILE_WIDTH'(1);
          buff_len_q <= therm;
        end
        LOAD: begin
          in_tile_q  <= '0;
          out_tile_q <= '0;
          col_q      <= '0;
          row_q      <= '0;
        end
        RUN: begin
          if (accepted) begin
            if (!in_tile_last) begin
              in_tile_q <= in_tile_q + TILE_WIDTH'(1);
            end else begin
              in_tile_q <= '0;
              if (!col_last) begin
                col_q <= col_q + DIM_WIDTH'(1);
              end else begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + DIM_WIDTH'(1);
              end
            end
          end
          drain_q <= 8'd1;
        end
        REARM: begin
          in_tile_q  <= '0;
          col_q      <= '0;
          row_q      <= '0;
          out_tile_q <= out_tile_q + TILE_WIDTH'(1);
        end
        DRAIN:   drain_q <= drain_q + 8'd1;
        default: ;
      endcase
    end
  end

  // acc_last travels through the multiplier and adder-tree latency alongside its window flag.
  always_comb begin
    lat_sr_d    = lat_sr_q << 1;
    lat_sr_d[0] = acc_last & win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lat_sr_q <= '0;
    else     lat_sr_q <= lat_sr_d;
  end

  assign in_ready      = (state_q == RUN);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign state_rst     = (state_q == LOAD);
  assign buff_len_rst  = (state_q == LOAD) | (state_q == REARM);
  assign adder_rst     = accepted & (in_tile_q == '0);
  assign acc_last      = accepted & in_tile_last;
  assign out_valid     = lat_sr_q[LAT-1];
  assign scale_in      = ((state_q == RUN) | (state_q == REARM) | (state_q == DRAIN)) ? scale_q : '0;
  assign PW_mode       = pw_q;
  assign buff_len_ctrl = buff_len_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: runs whole passes and checks event counts and timing.
module tb_conv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_pw_mode = 1'b0;
  logic [8:0] cfg_img_w = '0;
  logic [8:0] cfg_img_h = '0;
  logic [5:0] cfg_in_tiles = '0;
  logic [5:0] cfg_out_tiles = '0;
  logic [3:0] cfg_scale = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, busy, done, state_rst, adder_rst, acc_last, out_valid, PW_mode;
  logic       buff_len_rst;
  logic [3:0] scale_in;
  logic [8:0] buff_len_ctrl;

  conv_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_pw_mode   (cfg_pw_mode),
    .cfg_img_w     (cfg_img_w),
    .cfg_img_h     (cfg_img_h),
    .cfg_in_tiles  (cfg_in_tiles),
    .cfg_out_tiles (cfg_out_tiles),
    .cfg_scale     (cfg_scale),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .state_rst     (state_rst),
    .adder_rst     (adder_rst),
    .acc_last      (acc_last),
    .out_valid     (out_valid),
    .scale_in      (scale_in),
    .PW_mode       (PW_mode),
    .buff_len_ctrl (buff_len_ctrl),
    .buff_len_rst  (buff_len_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int cyc, beats, n_arst, n_alast, n_ov, n_rearm, n_done;
  int first_beat, last_beat, first_ov, last_ov, done_cyc, bad_parity, rearm_ready_bad;
  int scale_seen;
  bit gap_mode = 1'b0;

  task automatic clear_mon();
    cyc = 0; beats = 0; n_arst = 0; n_alast = 0; n_ov = 0; n_rearm = 0; n_done = 0;
    first_beat = -1; last_beat = -1; first_ov = -1; last_ov = -1; done_cyc = -1;
    bad_parity = 0; rearm_ready_bad = 0; scale_seen = -1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) begin
      if (beats == 0) first_beat = cyc;
      last_beat = cyc;
    end
    if (adder_rst) begin
      n_arst++;
      if (beats % 2 != 0) bad_parity++;
    end
    if (acc_last) begin
      n_alast++;
      if (beats % 2 != 1) bad_parity++;
    end
    if (out_valid) begin
      if (n_ov == 0) first_ov = cyc;
      last_ov = cyc;
      n_ov++;
    end
    if (buff_len_rst && !state_rst) begin
      n_rearm++;
      if (in_ready) rearm_ready_bad++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (in_ready) scale_seen = int'(scale_in);
    if (in_valid && in_ready) beats++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gap_mode) in_valid = 1'($urandom_range(0, 1));
    end
  end

  task automatic launch(input logic pw, input int w, input int h, input int it, input int ot,
                        input int sc);
    cfg_pw_mode   = pw;
    cfg_img_w     = 9'(w);
    cfg_img_h     = 9'(h);
    cfg_in_tiles  = 6'(it);
    cfg_out_tiles = 6'(ot);
    cfg_scale     = 4'(sc);
    @(posedge clk);
    #1;
    clear_mon();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    clear_mon();
    #12;
    check("reset_outputs", {10'd0, busy, in_ready, done, state_rst, adder_rst, acc_last,
          out_valid, buff_len_rst, PW_mode, scale_in, buff_len_ctrl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;

    // PW 4x2, one tile of each
    launch(1'b1, 4, 2, 1, 1, 5);
    wait_done(500);
    check("t1_done", n_done, 1);
    check("t1_beats", beats, 8);
    check("t1_adder_rst", n_arst, 8);
    check("t1_acc_last", n_alast, 8);
    check("t1_out_valid", n_ov, 8);
    check("t1_ov_latency", first_ov - first_beat, 4);
    check("t1_ov_contig", last_ov - first_ov, 7);
    check("t1_done_latency", done_cyc - last_beat, 4);
    check("t1_scale", scale_seen, 5);
    check("t1_pw_mode", PW_mode, 1);
    check("t1_buff_len", buff_len_ctrl, 9'h00F);
    check("t1_busy_after", busy, 0);
    check("t1_scale_idle", scale_in, 0);

    // 3x3 4x4, two input tiles
    launch(1'b0, 4, 4, 2, 1, 3);
    wait_done(500);
    check("t2_done", n_done, 1);
    check("t2_beats", beats, 32);
    check("t2_adder_rst", n_arst, 16);
    check("t2_acc_last", n_alast, 16);
    check("t2_tile_parity", bad_parity, 0);
    check("t2_out_valid", n_ov, 4);
    check("t2_buff_len", buff_len_ctrl, 9'h00F);
    check("t2_pw_mode", PW_mode, 0);

    // same, three output tiles
    launch(1'b0, 4, 4, 2, 3, 3);
    wait_done(1000);
    check("t3_done", n_done, 1);
    check("t3_rearm", n_rearm, 2);
    check("t3_rearm_ready", rearm_ready_bad, 0);
    check("t3_beats", beats, 96);
    check("t3_out_valid", n_ov, 12);

    // random in_valid gaps
    gap_mode = 1'b1;
    launch(1'b1, 3, 3, 3, 1, 7);
    wait_done(2000);
    gap_mode = 1'b0;
    in_valid = 1'b1;
    check("t4_done", n_done, 1);
    check("t4_beats", beats, 27);
    check("t4_adder_rst", n_arst, 9);
    check("t4_acc_last", n_alast, 9);
    check("t4_out_valid", n_ov, 9);

    // width clamp and zero in_tiles
    launch(1'b1, 20, 1, 0, 1, 1);
    wait_done(500);
    check("t5_done", n_done, 1);
    check("t5_buff_len", buff_len_ctrl, 9'h1FF);
    check("t5_beats", beats, 9);
    check("t5_adder_rst", n_arst, 9);
    check("t5_acc_last", n_alast, 9);
    check("t5_out_valid", n_ov, 9);

    // 3x3 too narrow for any window
    launch(1'b0, 2, 4, 1, 1, 1);
    wait_done(500);
    check("t6_done", n_done, 1);
    check("t6_beats", beats, 8);
    check("t6_out_valid", n_ov, 0);
    check("t6_buff_len", buff_len_ctrl, 9'h003);

    // start while busy must not relaunch or relatch
    launch(1'b0, 4, 4, 2, 1, 3);
    repeat (10) @(posedge clk);
    #1;
    cfg_img_w = 9'd2;
    cfg_pw_mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(500);
    check("t7_done", n_done, 1);
    check("t7_beats", beats, 32);
    check("t7_out_valid", n_ov, 4);
    check("t7_pw_mode", PW_mode, 0);

    // async reset mid-RUN
    launch(1'b1, 9, 9, 2, 2, 6);
    repeat (20) @(negedge clk);
    check("t8_running", in_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t8_rst_outputs", {10'd0, busy, in_ready, done, state_rst, adder_rst, acc_last,
          out_valid, buff_len_rst, PW_mode, scale_in, buff_len_ctrl}, 32'd0);
    clear_mon();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("t8_no_done", n_done, 0);
    check("t8_idle", busy, 0);

    launch(1'b1, 4, 2, 1, 1, 2);
    wait_done(500);
    check("t9_done", n_done, 1);
    check("t9_beats", beats, 8);
    check("t9_out_valid", n_ov, 8);
    check("t9_done_latency", done_cyc - last_beat, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
